// File: rtl/apb_master_bridge_if.sv
// Command port and APB bus bundle for the command-to-APB master bridge.
// The master modport is the bridge's view; the slave modport is the view of
// whatever drives commands and plays the APB slave (the surrounding system).
interface apb_master_bridge_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  // command side
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  // response side
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  // APB side
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Command-to-APB master bridge: takes single read/write commands from a
// valid/ready port, runs them through APB SETUP/ACCESS toward one slave and
// returns data, slave error and timeout status on a one-cycle response strobe.
module apb_master_bridge #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                CLK,
  input  logic                Rst,
  apb_master_bridge_if.master bus,
  output logic [1:0]          state
);

  // Counter just wide enough to hold TIMEOUT-1, the last tolerated wait.
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic              psel_reg, psel_next;
  logic              penable_reg, penable_next;
  logic              pwrite_reg, pwrite_next;
  logic [ADDR_W-1:0] paddr_reg, paddr_next;
  logic [DATA_W-1:0] pwdata_reg, pwdata_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic              rsp_err_reg, rsp_err_next;
  logic              rsp_timeout_reg, rsp_timeout_next;

  logic ready;
  logic accept;
  logic complete;
  logic at_limit;
  logic abort;

  // Ready in IDLE, or in the completing ACCESS cycle so a new command can
  // chain straight into SETUP. Held low while reset is asserted so nothing
  // is accepted and every output reads 0 during reset.
  assign ready    = !Rst && ((state_reg == IDLE) ||
                             ((state_reg == ACCESS) && bus.PREADY));
  assign accept   = bus.cmd_valid && ready;
  assign complete = (state_reg == ACCESS) && bus.PREADY;
  assign at_limit = (wait_cnt_reg == CNT_W'(TIMEOUT - 1));
  assign abort    = (state_reg == ACCESS) && !bus.PREADY && at_limit;

  // State and all registered outputs; reset clears everything at once.
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      state_reg       <= IDLE;
      wait_cnt_reg    <= '0;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
      pwrite_reg      <= 1'b0;
      paddr_reg       <= '0;
      pwdata_reg      <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      psel_reg        <= psel_next;
      penable_reg     <= penable_next;
      pwrite_reg      <= pwrite_next;
      paddr_reg       <= paddr_next;
      pwdata_reg      <= pwdata_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_err_reg     <= rsp_err_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

  // Next-state: SETUP always lasts one cycle; ACCESS ends on PREADY or abort.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS: begin
        if (complete)   state_next = accept ? SETUP : IDLE;
        else if (abort) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs, the wait counter and the response.
  always_comb begin
    psel_next        = (state_next == SETUP) || (state_next == ACCESS);
    penable_next     = (state_next == ACCESS);
    // Address/direction/data only change on acceptance, so they stay stable
    // through SETUP and ACCESS and hold their last values in IDLE.
    paddr_next       = accept ? bus.cmd_addr  : paddr_reg;
    pwrite_next      = accept ? bus.cmd_write : pwrite_reg;
    pwdata_next      = pwdata_reg;
    if (accept) pwdata_next = bus.cmd_write ? bus.cmd_wdata : '0;

    wait_cnt_next    = wait_cnt_reg;
    if (accept || abort)
      wait_cnt_next = '0;
    else if ((state_reg == ACCESS) && !bus.PREADY)
      wait_cnt_next = wait_cnt_reg + CNT_W'(1);

    rsp_valid_next   = complete || abort;
    rsp_rdata_next   = (complete && !pwrite_reg) ? bus.PRDATA : '0;
    rsp_err_next     = complete ? bus.PSLVERR : abort;
    rsp_timeout_next = abort;
  end

  assign bus.cmd_ready   = ready;
  assign bus.PSEL        = psel_reg;
  assign bus.PENABLE     = penable_reg;
  assign bus.PWRITE      = pwrite_reg;
  assign bus.PADDR       = paddr_reg;
  assign bus.PWDATA      = pwdata_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_rdata   = rsp_rdata_reg;
  assign bus.rsp_err     = rsp_err_reg;
  assign bus.rsp_timeout = rsp_timeout_reg;
  assign state           = state_reg;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: a table of single transfers plus hand-written
// back-to-back, timeout and mid-transfer reset sequences. A second bridge
// with TIMEOUT=4 shares all inputs so the short timeout can be observed.
module tb_apb_master_bridge;

  logic       CLK;
  logic       Rst;
  logic [1:0] st_main;
  logic [1:0] st_t4;
  logic       use_ovr;
  logic [7:0] ovr_rdata;
  logic [7:0] mem [32];

  int n_chk  = 0;
  int n_fail = 0;

  apb_master_bridge_if #(.ADDR_W(5), .DATA_W(8)) bus ();
  apb_master_bridge_if #(.ADDR_W(5), .DATA_W(8)) bus4 ();

  apb_master_bridge #(.ADDR_W(5), .DATA_W(8), .TIMEOUT(16)) dut (
    .CLK(CLK), .Rst(Rst), .bus(bus.master), .state(st_main)
  );

  apb_master_bridge #(.ADDR_W(5), .DATA_W(8), .TIMEOUT(4)) dut_t4 (
    .CLK(CLK), .Rst(Rst), .bus(bus4.master), .state(st_t4)
  );

  // simple APB slave: storage for back-to-back, or a forced read value
  assign bus.PRDATA     = use_ovr ? ovr_rdata : mem[bus.PADDR];
  assign bus4.PRDATA    = bus.PRDATA;
  assign bus4.PREADY    = bus.PREADY;
  assign bus4.PSLVERR   = bus.PSLVERR;
  assign bus4.cmd_valid = bus.cmd_valid;
  assign bus4.cmd_write = bus.cmd_write;
  assign bus4.cmd_addr  = bus.cmd_addr;
  assign bus4.cmd_wdata = bus.cmd_wdata;

  always @(posedge CLK)
    if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE)
      mem[bus.PADDR] <= bus.PWDATA;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       wr;
    logic [4:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic [7:0] slv_rdata;
    logic       slv_err;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  vec_t vecs [6];

  // Wait (bounded) for cmd_ready with the command already driven.
  task automatic wait_ready(input string name);
    int g = 0;
    #1;
    while (!bus.cmd_ready && g < 20) begin
      @(negedge CLK);
      #1;
      g++;
    end
    chk(name, bus.cmd_ready, 1);
  endtask

  // One isolated transfer with v.waits wait states, checked cycle by cycle.
  task automatic do_txn(input int id, input vec_t v);
    @(negedge CLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = v.slv_err;
    use_ovr       = 1'b1;
    ovr_rdata     = v.slv_rdata;
    wait_ready("txn_ready");
    @(posedge CLK);
    @(negedge CLK);
    bus.cmd_valid = 1'b0;
    chk("setup_state", st_main, 2'b01);
    chk("setup_psel", bus.PSEL, 1);
    chk("setup_penable", bus.PENABLE, 0);
    chk("setup_paddr", bus.PADDR, v.addr);
    chk("setup_pwrite", bus.PWRITE, v.wr);
    chk("setup_pwdata", bus.PWDATA, v.wr ? v.wdata : 8'h00);
    chk("setup_ready", bus.cmd_ready, 0);
    for (int w = 0; w < v.waits; w++) begin
      @(negedge CLK);
      chk("wait_state", st_main, 2'b10);
      chk("wait_penable", bus.PENABLE, 1);
      chk("wait_paddr", bus.PADDR, v.addr);
      chk("wait_rsp_valid", bus.rsp_valid, 0);
    end
    @(negedge CLK);
    chk("access_state", st_main, 2'b10);
    chk("access_psel", bus.PSEL, 1);
    chk("access_penable", bus.PENABLE, 1);
    chk("access_paddr", bus.PADDR, v.addr);
    chk("access_rsp_valid", bus.rsp_valid, 0);
    bus.PREADY = 1'b1;
    @(negedge CLK);
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    chk("rsp_err", bus.rsp_err, v.exp_err);
    chk("rsp_timeout", bus.rsp_timeout, 0);
    chk("done_state", st_main, 2'b00);
    chk("done_psel", bus.PSEL, 0);
    chk("t4_rsp_valid", bus4.rsp_valid, 1);
    chk("t4_rsp_rdata", bus4.rsp_rdata, v.exp_rdata);
    @(negedge CLK);
    chk("rsp_clear", bus.rsp_valid, 0);
    chk("rsp_rdata_clear", bus.rsp_rdata, 0);
    $display("txn %0d: %s addr=%h wdata=%h waits=%0d rdata=%h err=%0d",
             id, v.wr ? "WR" : "RD", v.addr, v.wdata, v.waits, v.exp_rdata, v.exp_err);
  endtask

  initial begin
    //           wr    addr   wdata  waits slv_rd slv_err exp_rd exp_err
    vecs[0] = '{1'b1, 5'h03, 8'hA5, 0,    8'hEE, 1'b0,   8'h00, 1'b0};
    vecs[1] = '{1'b0, 5'h1C, 8'h00, 2,    8'h5A, 1'b0,   8'h5A, 1'b0};
    vecs[2] = '{1'b0, 5'h1F, 8'h00, 0,    8'hC3, 1'b1,   8'hC3, 1'b1};
    vecs[3] = '{1'b1, 5'h0A, 8'h3C, 1,    8'h99, 1'b1,   8'h00, 1'b1};
    vecs[4] = '{1'b0, 5'h00, 8'h00, 3,    8'hFF, 1'b0,   8'hFF, 1'b0};
    vecs[5] = '{1'b1, 5'h1F, 8'h00, 0,    8'h12, 1'b0,   8'h00, 1'b0};

    Rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    use_ovr       = 1'b1;
    ovr_rdata     = 8'h00;

    // reset state
    #1;
    chk("rst_state", st_main, 2'b00);
    chk("rst_psel", bus.PSEL, 0);
    chk("rst_penable", bus.PENABLE, 0);
    chk("rst_paddr", bus.PADDR, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    @(negedge CLK);
    @(negedge CLK);
    Rst = 1'b0;
    #1;
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    $display("reset released");

    // table of isolated transfers
    for (int i = 0; i < 6; i++) do_txn(i, vecs[i]);

    // back-to-back: write 01/11 then read 01 with cmd_valid held
    @(negedge CLK);
    use_ovr       = 1'b0;
    bus.PREADY    = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 5'h01;
    bus.cmd_wdata = 8'h11;
    wait_ready("b2b_ready");
    @(posedge CLK);
    @(negedge CLK);
    chk("b2b_setup1", st_main, 2'b01);
    chk("b2b_setup1_ready", bus.cmd_ready, 0);
    bus.cmd_write = 1'b0;
    bus.cmd_wdata = 8'h00;
    @(negedge CLK);
    chk("b2b_access1", st_main, 2'b10);
    chk("b2b_access1_ready", bus.cmd_ready, 1);
    @(negedge CLK);
    bus.cmd_valid = 1'b0;
    chk("b2b_setup2", st_main, 2'b01);
    chk("b2b_psel_held", bus.PSEL, 1);
    chk("b2b_penable2", bus.PENABLE, 0);
    chk("b2b_pwrite2", bus.PWRITE, 0);
    chk("b2b_pwdata2", bus.PWDATA, 0);
    chk("b2b_rsp1_valid", bus.rsp_valid, 1);
    chk("b2b_rsp1_rdata", bus.rsp_rdata, 0);
    @(negedge CLK);
    chk("b2b_access2", st_main, 2'b10);
    chk("b2b_access2_psel", bus.PSEL, 1);
    chk("b2b_rsp_gap", bus.rsp_valid, 0);
    @(negedge CLK);
    bus.PREADY = 1'b0;
    chk("b2b_rsp2_valid", bus.rsp_valid, 1);
    chk("b2b_rsp2_rdata", bus.rsp_rdata, 8'h11);
    chk("b2b_rsp2_err", bus.rsp_err, 0);
    chk("b2b_idle", st_main, 2'b00);
    $display("b2b: WR 01=11 then RD 01 -> %h", bus.rsp_rdata);

    // timeout: PREADY held low; TIMEOUT=4 instance aborts first
    @(negedge CLK);
    use_ovr       = 1'b1;
    ovr_rdata     = 8'h77;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 5'h05;
    wait_ready("to_ready");
    @(posedge CLK);
    for (int k = 1; k <= 18; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        bus.cmd_valid = 1'b0;
        chk("to4_setup", st_t4, 2'b01);
      end
      if (k >= 2 && k <= 5) begin
        chk("to4_access", st_t4, 2'b10);
        chk("to4_penable", bus4.PENABLE, 1);
        chk("to4_no_rsp", bus4.rsp_valid, 0);
      end
      if (k == 5) chk("to4_ready_low", bus4.cmd_ready, 0);
      if (k == 6) begin
        chk("to4_rsp_valid", bus4.rsp_valid, 1);
        chk("to4_rsp_err", bus4.rsp_err, 1);
        chk("to4_rsp_timeout", bus4.rsp_timeout, 1);
        chk("to4_rsp_rdata", bus4.rsp_rdata, 0);
        chk("to4_idle", st_t4, 2'b00);
        chk("to4_psel", bus4.PSEL, 0);
        chk("to16_still_access", st_main, 2'b10);
      end
      if (k == 7) chk("to4_rsp_clear", bus4.rsp_valid, 0);
      if (k == 17) begin
        chk("to16_last_access", st_main, 2'b10);
        chk("to16_no_rsp", bus.rsp_valid, 0);
      end
      if (k == 18) begin
        chk("to16_rsp_valid", bus.rsp_valid, 1);
        chk("to16_rsp_err", bus.rsp_err, 1);
        chk("to16_rsp_timeout", bus.rsp_timeout, 1);
        chk("to16_rsp_rdata", bus.rsp_rdata, 0);
        chk("to16_idle", st_main, 2'b00);
      end
    end
    $display("timeout: T4 abort rsp and T16 abort rsp observed");
    do_txn(10, '{1'b0, 5'h06, 8'h00, 1, 8'h6B, 1'b0, 8'h6B, 1'b0});

    // reset in the middle of ACCESS
    @(negedge CLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 5'h07;
    bus.PREADY    = 1'b0;
    wait_ready("rst_seq_ready");
    @(posedge CLK);
    @(negedge CLK);
    bus.cmd_valid = 1'b0;
    @(negedge CLK);
    chk("pre_rst_access", st_main, 2'b10);
    #2;
    Rst = 1'b1;
    #1;
    chk("async_psel", bus.PSEL, 0);
    chk("async_penable", bus.PENABLE, 0);
    chk("async_state", st_main, 2'b00);
    chk("async_t4_psel", bus4.PSEL, 0);
    @(negedge CLK);
    Rst        = 1'b0;
    bus.PREADY = 1'b1;
    chk("post_rst_rsp", bus.rsp_valid, 0);
    @(negedge CLK);
    bus.PREADY = 1'b0;
    chk("post_rst_rsp2", bus.rsp_valid, 0);
    chk("post_rst_idle", st_main, 2'b00);
    $display("reset mid-access: bus released, no response");
    do_txn(11, '{1'b1, 5'h15, 8'h9E, 0, 8'h00, 1'b0, 8'h00, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Command-to-APB master bridge.
- Accepts single read/write commands from a simple valid/ready command port.
- Sequences each command through APB IDLE -> SETUP -> ACCESS phases toward one APB slave (5-bit address, 8-bit data).
- Returns read data, slave error and timeout status on a one-cycle response strobe.
- Sits directly upstream of the APB slave; its APB outputs connect straight to the slave's PSEL/PENABLE/PWRITE/PADDR/PWDATA inputs.

Parameters:
ADDR_W, 5, APB address width.
DATA_W, 8, APB data width.
TIMEOUT, 16, number of ACCESS cycles with PREADY low before the transfer is aborted; legal range 2..255.

Ports:
CLK  input  1  clock.
Rst  input  1  asynchronous active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  bridge accepts command this cycle.
cmd_write  input  1  1 = write, 0 = read.
cmd_addr  input  ADDR_W  transfer address.
cmd_wdata  input  DATA_W  write data.
rsp_valid  output  1  one-cycle response strobe.
rsp_rdata  output  DATA_W  read data; 0 for writes and timeouts.
rsp_err  output  1  PSLVERR sampled at completion, or timeout.
rsp_timeout  output  1  transfer aborted by timeout.
PSEL  output  1  APB select.
PENABLE  output  1  APB enable.
PWRITE  output  1  APB direction.
PADDR  output  ADDR_W  APB address.
PWDATA  output  DATA_W  APB write data.
PREADY  input  1  slave ready.
PRDATA  input  DATA_W  slave read data.
PSLVERR  input  1  slave error.
state  output  2  current state: IDLE=00, SETUP=01, ACCESS=10.

Behaviour:
Reset:
- Rst high forces, immediately and asynchronously: state=IDLE, every output 0, wait counter 0.
- Reset during SETUP/ACCESS drops PSEL/PENABLE at once. No response is issued for the aborted transfer.

Outputs and handshake:
- All APB outputs and rsp_* are registered.
- cmd_ready is combinational: 1 when state==IDLE, or when state==ACCESS && PREADY==1 (back-to-back acceptance). It is 0 in SETUP and in the timeout cycle.
- Command accepted on a rising edge where cmd_valid && cmd_ready. At that edge PADDR/PWRITE/PWDATA load from cmd_*; PWDATA loads 0 for reads.

State transitions:
- IDLE: PSEL=0, PENABLE=0. Accept -> SETUP.
- SETUP: PSEL=1, PENABLE=0. Unconditionally -> ACCESS next cycle.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA stay stable throughout SETUP and ACCESS.
  - PREADY=1: transfer completes at this edge. If a command is accepted at the same edge -> SETUP (PSEL stays 1, PENABLE 0); otherwise -> IDLE.
  - PREADY=0: wait counter increments. When the counter reaches TIMEOUT-1 with PREADY still low, the transfer aborts -> IDLE.

Response:
- Completion: rsp_valid=1 for exactly the following cycle.
  - rsp_rdata = PRDATA sampled at the completion edge for reads, 0 for writes.
  - rsp_err = PSLVERR sampled at the completion edge.
  - rsp_timeout = 0.
- Timeout: rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- rsp_* return to 0 the cycle after the strobe unless another completion occurs.

Counter and latency:
- Wait counter clears on entry to SETUP; width is ceil(log2(TIMEOUT)).
- Zero-wait latency: command accepted at edge N -> SETUP cycle N+1 -> ACCESS cycle N+2 -> rsp_valid cycle N+3.
- Each wait state adds one cycle.
- Back-to-back throughput: one transfer per 2 cycles.

Misc:
- PREADY/PSLVERR/PRDATA are ignored outside ACCESS.
- In IDLE, PADDR/PWRITE/PWDATA hold their last values.

Test Plan:
- Write addr 5'h03 data 8'hA5, PREADY tied 1 -> PSEL 1 for 2 cycles, PENABLE 1 in the 2nd; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read addr 5'h1C, slave returns 8'h5A after 2 wait states -> ACCESS lasts 3 cycles, PADDR stable throughout; rsp_rdata=8'h5A 5 cycles after accept.
- Back-to-back write 5'h01/8'h11 then read 5'h01 with cmd_valid held -> second accepted in the first's completion cycle; PSEL never drops; read returns 8'h11.
- Slave asserts PSLVERR with PREADY on read of 5'h1F -> rsp_err=1, rsp_timeout=0, rsp_rdata=PRDATA.
- TIMEOUT=4, PREADY held 0 -> abort after 4 ACCESS cycles; rsp_err=1, rsp_timeout=1; state IDLE; next command proceeds normally.
- Rst pulsed mid-ACCESS -> PSEL/PENABLE 0 immediately, no rsp_valid; a fresh write after reset completes correctly.
